addsub_serial_seq: RTL and testbench
====================================

// Module: addsub_serial_seq
// PURPOSE
//  Multi-cycle add/subtract sequencer. Extends the 2-bit plus/minus ALU datapath to WIDTH-bit operands.
//  Each cycle it feeds one 2-bit slice of the operands through a carry-chained 2-bit add/sub slice.
//  It registers the carry/borrow between slices and assembles the WIDTH-bit result.
//  Sits between the operand switches/registers (upstream) and the result consumer (downstream).
//  Valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be even and >= 2; slices = WIDTH/2
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      operands a/b/sub valid
//  in_ready     out  1      block can accept operands (high only in IDLE)
//  a            in   WIDTH  first operand (minuend for sub)
//  b            in   WIDTH  second operand (subtrahend for sub)
//  sub          in   1      0 = a+b, 1 = a-b (same sense as ALU select s)
//  out_valid    out  1      result/flags valid (high only in DONE)
//  out_ready    in   1      consumer takes result
//  result       out  WIDTH  a+b or a-b, modulo 2^WIDTH
//  co           out  1      add: carry out of MSB; sub: borrow (1 when a < b unsigned)
//  ovf          out  1      two's-complement signed overflow
// BEHAVIOUR
//  Reset values:
//  - state=IDLE, in_ready=1, out_valid=0, result=0, co=0, ovf=0.
//  - Internal shift registers, slice counter and carry are cleared.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//  - On in_valid&&in_ready: latch a, b, sub; set slice counter=0 and carry_reg=sub.
//  - Move to RUN.
//  RUN (in_ready=0, out_valid=0), one slice per cycle, LSB slice first:
//  - {c,s[1:0]} = a_sh[1:0] + (b_sh[1:0] ^ {2{sub}}) + carry_reg   (3-bit arithmetic)
//  - s[1:0] shifts into the result register from the MSB side.
//  - a_sh and b_sh shift right by 2.
//  - carry_reg <= c.
//  - On the last slice (counter == WIDTH/2-1), move to DONE:
//    - co = c ^ sub.
//    - ovf = carry into MSB xor carry out of MSB (bit-level carry inside the last slice).
//  Latency:
//  - Accept edge E0; out_valid rises after edge E0+WIDTH/2 (WIDTH=8: 4 edges).
//  - Throughput: one operation per WIDTH/2+2 cycles.
//  DONE:
//  - result/co/ovf held stable while out_valid=1 && !out_ready.
//  - On out_ready, move to IDLE; outputs keep their last values, but out_valid drops.
//  - New operands are accepted only from IDLE, so there is no same-cycle hand-off.
//  Input changes: a/b/sub are ignored whenever in_ready=0; only the values latched at acceptance are used.
//  Reset asserted in any state (including mid-RUN):
//  - Next edge gives IDLE and reset values.
//  - A partial result is never presented.
//  Boundaries:
//  - 0 - 0 gives result 0, co=0.
//  - Full-scale wrap: 0xFF+0x01 gives 0x00, co=1.
//  - Sub of equal operands gives 0, co=0.
// STRUCTURE
//  Shared package (addsub_pkg):
//  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  - Op-select constants OP_ADD=1'b0, OP_SUB=1'b1.
//  Sub-module addsub2_slice (combinational):
//  - Inputs: a[1:0], b[1:0], sub, ci. Outputs: s[1:0], co, c_msb (carry into bit 1).
//  - Built from two full adders, b xor sub.
//  - The sequencer instantiates one slice.
//  - The sequencer keeps FSM, counter ($clog2(WIDTH/2) bits, min 1), shift registers and carry register.
// TESTING  (WIDTH=8)
//  1. Add: a=0x35, b=0x4A, sub=0 -> out_valid 4 edges after accept; result=0x7F, co=0, ovf=0.
//  2. Sub with borrow: a=0x10, b=0x20, sub=1 -> result=0xF0, co=1, ovf=0.
//     Also a=0x20, b=0x20 -> result=0x00, co=0.
//  3. Flags:
//     - 0x7F+0x01 -> result=0x80, co=0, ovf=1.
//     - 0xFF+0x01 -> result=0x00, co=1, ovf=0.
//     - 0x80-0x01 -> result=0x7F, ovf=1.
//  4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> result/flags stable, in_ready=0.
//     Toggle a/b during RUN -> result unaffected.
//  5. Reset mid-op: assert rst at second RUN cycle -> next edge: in_ready=1, out_valid=0, result=0, co=0, ovf=0.
//     Next op a=0x01, b=0x02 -> result=0x03.
//  6. Back-to-back random: 1000 ops with random in_valid/out_ready.
//     Scoreboard: (a±b) mod 256, co and ovf against a reference model.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants for the serial add/subtract sequencer.
//   ST_*  : sequencer state encoding (IDLE -> RUN -> DONE -> IDLE)
//   OP_*  : operation select, same sense as the ALU 's' input
package addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub2_slice.sv
// Combinational 2-bit add/subtract slice built from two full adders.
// Ports:
//   a, b  : 2-bit operand slices
//   sub   : 1 inverts b (two's-complement subtract when ci = 1 on the LSB slice)
//   ci    : carry in
//   s     : 2-bit sum
//   co    : carry out of bit 1
//   c_msb : carry into bit 1 (used for signed overflow on the top slice)
module addsub2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       sub,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co,
  output logic       c_msb
);

  logic [1:0] bx;

  always_comb begin
    bx    = b ^ {2{sub}};
    s[0]  = a[0] ^ bx[0] ^ ci;
    c_msb = (a[0] & bx[0]) | (a[0] & ci) | (bx[0] & ci);
    s[1]  = a[1] ^ bx[1] ^ c_msb;
    co    = (a[1] & bx[1]) | (a[1] & c_msb) | (bx[1] & c_msb);
  end

endmodule

// File: rtl/addsub_serial_seq.sv
// Multi-cycle WIDTH-bit add/subtract sequencer: one 2-bit slice per cycle, LSB slice first,
// with the carry/borrow registered between slices. Valid/ready on both sides.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (ready only in IDLE)
//   a, b, sub             : operands and op select (0 = a+b, 1 = a-b)
//   out_valid/out_ready   : result handshake (valid only in DONE)
//   result, co, ovf       : sum/difference, carry (add) or borrow (sub), signed overflow
module addsub_serial_seq
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned SLICES = WIDTH / 2;
  localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, result_q;
  logic             carry_q, sub_q, co_q, ovf_q;

  logic [1:0]       sl_s;
  logic             sl_co, sl_c_msb;
  logic [WIDTH-1:0] acc_next;

  addsub2_slice u_slice (
    .a     (a_sh_q[1:0]),
    .b     (b_sh_q[1:0]),
    .sub   (sub_q),
    .ci    (carry_q),
    .s     (sl_s),
    .co    (sl_co),
    .c_msb (sl_c_msb)
  );

  // New slice enters from the MSB side; after SLICES steps the LSB slice sits at bit 0.
  always_comb begin
    acc_next = WIDTH'({sl_s, acc_q} >> 2);
  end

  // The partial sum lives in acc_q; result_q only changes on the last slice, so a
  // partial result never appears on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      sub_q    <= OP_ADD;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            sub_q   <= sub;
            carry_q <= sub;  // +1 of the two's-complement negate
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh_q  <= a_sh_q >> 2;
          b_sh_q  <= b_sh_q >> 2;
          acc_q   <= acc_next;
          carry_q <= sl_co;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_q <= acc_next;
            co_q     <= sl_co ^ sub_q;  // invert carry into borrow for subtract
            ovf_q    <= sl_co ^ sl_c_msb;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_serial_seq.sv
module tb_addsub_serial_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, sub, out_valid, out_ready, co, ovf;
  logic [7:0] a, b, result;

  int checks = 0;
  int errors = 0;

  addsub_serial_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .co        (co),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic       co;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       co;
    logic       ovf;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
    exp_t e;
    int   xs, ys, r;
    xs = (x >= 128) ? int'(x) - 256 : int'(x);
    ys = (y >= 128) ? int'(y) - 256 : int'(y);
    if (!s) begin
      e.res = 8'((int'(x) + int'(y)) % 256);
      e.co  = (int'(x) + int'(y)) > 255;
      r     = xs + ys;
    end else begin
      e.res = 8'((int'(x) - int'(y) + 256) % 256);
      e.co  = x < y;
      r     = xs - ys;
    end
    e.ovf = (r > 127) || (r < -128);
    return e;
  endfunction

  // One operation from IDLE: accept, wait for DONE (bounded), return latency in edges.
  task automatic start_and_wait(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                                input bit toggle, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (toggle) begin
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    check("done_reached", 32'(out_valid), 32'd1);
  endtask

  task automatic release_result(input logic [7:0] er, input logic eco, input logic eovf);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drops", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("result_kept", 32'(result), 32'(er));
    check("flags_kept", 32'({co, ovf}), 32'({eco, eovf}));
  endtask

  vec_t vecs[7];
  exp_t sbq[$];

  initial begin
    int   lat;
    int   ops;
    int   cyc;
    exp_t e;
    logic [7:0] hr;
    logic       hco, hovf;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h20, 8'h20, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({co, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; odd entries scramble a/b/sub while RUN is in progress.
    for (int i = 0; i < 7; i++) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].sub, (i % 2) == 1, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
      check($sformatf("vec%0d_co", i), 32'(co), 32'(vecs[i].co));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      release_result(vecs[i].res, vecs[i].co, vecs[i].ovf);
    end

    // Backpressure: DONE held for 10 cycles with changing inputs.
    start_and_wait(8'h5A, 8'hC3, 1'b1, 1'b1, lat);
    e = model(8'h5A, 8'hC3, 1'b1);
    hr = result; hco = co; hovf = ovf;
    check("bp_result", 32'(result), 32'(e.res));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_stable", 32'({result, co, ovf}), 32'({hr, hco, hovf}));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_result(e.res, e.co, e.ovf);

    // Reset in the second RUN cycle.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_flags", 32'({co, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_and_wait(8'h01, 8'h02, 1'b0, 1'b0, lat);
    check("post_rst_result", 32'(result), 32'h03);
    release_result(8'h03, 1'b0, 1'b0);

    // Random back-to-back traffic against the model with a scoreboard queue.
    ops = 0;
    cyc = 0;
    while (ops < 1000 && cyc < 40000) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) sbq.push_back(model(a, b, sub));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("rand_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("rand_result", 32'(result), 32'(e.res));
          check("rand_co", 32'(co), 32'(e.co));
          check("rand_ovf", 32'(ovf), 32'(e.ovf));
        end
        ops++;
      end
      cyc++;
    end
    check("rand_ops_completed", 32'(ops), 32'd1000);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
